mem_port_arbiter: RTL and testbench

- Shares one single-ported, pipelined, word-wide memory between the instruction-fetch port and the load/store (MEM-stage) port.
- Used by the unified-memory variant of the core, which has one memory instead of separate instruction and data memories.
- Grants at most one request per cycle and routes read data back one cycle later to the owner.
- Produces grant signals that the pipeline converts into stalls, and enforces fetch anti-starvation.

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/mem_arb_starve_ctr.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 102 ++++++++++
 tb/tb_mem_port_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned STARVE_CNT_W = 4;

    // Owner of the read response returning from memory this cycle.
    typedef enum logic [1:0] {
        RESP_NONE  = 2'd0,
        RESP_FETCH = 2'd1,
        RESP_DATA  = 2'd2
    } resp_owner_t;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Counts consecutive denied fetch cycles and raises force_fetch_c once the
// limit is reached, so fetch cannot be starved by a stream of data accesses.
module mem_arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_STARVE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic fetch_req,
    input  logic fetch_gnt,
    output logic force_fetch_c
);

    localparam logic [STARVE_CNT_W-1:0] MAX_CNT = STARVE_CNT_W'(MAX_STARVE);

    logic [STARVE_CNT_W-1:0] starve_cnt_q;
    logic [STARVE_CNT_W-1:0] starve_cnt_d;

    // Saturating count of denied fetch cycles; any grant or idle fetch clears it.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!fetch_req || fetch_gnt) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != MAX_CNT) begin
            starve_cnt_d = starve_cnt_q + STARVE_CNT_W'(1);
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign force_fetch_c = (starve_cnt_q == MAX_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported pipelined memory between the fetch port and
// the load/store port. Grants are combinational; read data returns one cycle
// after the grant to whichever port owned the access.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADR_W      = 32,
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned MAX_STARVE = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_req,
    input  logic [ADR_W-1:0]      fetch_adr,
    input  logic                  fetch_kill,
    output logic                  fetch_gnt,
    output logic                  fetch_rvalid,
    output logic [WORD_W-1:0]     fetch_rdata,
    input  logic                  data_req,
    input  logic                  data_we,
    input  logic [ADR_W-1:0]      data_adr,
    input  logic [WORD_W-1:0]     data_wdata,
    input  logic [(WORD_W/8)-1:0] data_wmask,
    output logic                  data_gnt,
    output logic                  data_rvalid,
    output logic [WORD_W-1:0]     data_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADR_W-1:0]      mem_adr,
    output logic [WORD_W-1:0]     mem_wdata,
    output logic [(WORD_W/8)-1:0] mem_wmask,
    input  logic [WORD_W-1:0]     mem_rdata
);

    logic        force_fetch_c;
    resp_owner_t resp_owner_q;
    resp_owner_t resp_owner_d;

    mem_arb_starve_ctr #(
        .MAX_STARVE (MAX_STARVE)
    ) u_starve_ctr (
        .clk           (clk),
        .reset         (reset),
        .fetch_req     (fetch_req),
        .fetch_gnt     (fetch_gnt),
        .force_fetch_c (force_fetch_c)
    );

    // Grant selection: data by default, fetch when alone or starved; none in reset.
    always_comb begin
        fetch_gnt = 1'b0;
        data_gnt  = 1'b0;
        if (reset) begin
            fetch_gnt = fetch_req & (~data_req | force_fetch_c);
            data_gnt  = data_req & ~fetch_gnt;
        end
    end

    // Memory command driven by the granted port; idle memory sees all zeros.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_adr   = '0;
        mem_wdata = '0;
        mem_wmask = '0;
        if (fetch_gnt) begin
            mem_en  = 1'b1;
            mem_adr = fetch_adr;
        end else if (data_gnt) begin
            mem_en    = 1'b1;
            mem_we    = data_we;
            mem_adr   = data_adr;
            mem_wdata = data_wdata;
            mem_wmask = data_we ? data_wmask : '0;
        end
    end

    // Next response owner: only unkilled fetches and loads expect data back.
    always_comb begin
        resp_owner_d = RESP_NONE;
        if (fetch_gnt && !fetch_kill) begin
            resp_owner_d = RESP_FETCH;
        end else if (data_gnt && !data_we) begin
            resp_owner_d = RESP_DATA;
        end
    end

    // Response owner register; reset drops any response in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            resp_owner_q <= RESP_NONE;
        end else begin
            resp_owner_q <= resp_owner_d;
        end
    end

    assign fetch_rvalid = (resp_owner_q == RESP_FETCH);
    assign data_rvalid  = (resp_owner_q == RESP_DATA);
    assign fetch_rdata  = fetch_rvalid ? mem_rdata : '0;
    assign data_rdata   = data_rvalid  ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural pipelined memory and
// a per-cycle response scoreboard.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        fetch_req;
    logic [31:0] fetch_adr;
    logic        fetch_kill;
    logic        fetch_gnt;
    logic        fetch_rvalid;
    logic [31:0] fetch_rdata;
    logic        data_req;
    logic        data_we;
    logic [31:0] data_adr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wmask;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_adr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;

    typedef struct {
        logic        fv;
        logic [31:0] fd;
        logic        dv;
        logic [31:0] dd;
    } resp_t;

    resp_t       sb[$];
    logic [31:0] mem[64];
    logic [31:0] ref_mem[64];
    int          total = 0;
    int          bad   = 0;

    mem_port_arbiter #(
        .ADR_W      (32),
        .WORD_W     (32),
        .MAX_STARVE (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .fetch_req    (fetch_req),
        .fetch_adr    (fetch_adr),
        .fetch_kill   (fetch_kill),
        .fetch_gnt    (fetch_gnt),
        .fetch_rvalid (fetch_rvalid),
        .fetch_rdata  (fetch_rdata),
        .data_req     (data_req),
        .data_we      (data_we),
        .data_adr     (data_adr),
        .data_wdata   (data_wdata),
        .data_wmask   (data_wmask),
        .data_gnt     (data_gnt),
        .data_rvalid  (data_rvalid),
        .data_rdata   (data_rdata),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_adr      (mem_adr),
        .mem_wdata    (mem_wdata),
        .mem_wmask    (mem_wmask),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pipelined memory: read data one cycle after the command, junk otherwise.
    always @(posedge clk) begin
        if (mem_en && !mem_we) begin
            mem_rdata <= mem[mem_adr[7:2]];
        end else begin
            mem_rdata <= $urandom;
        end
        if (mem_en && mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wmask[b]) mem[mem_adr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check grants/memory/response at negedge, push next response.
    task automatic step(input logic rst_n, input logic pre_rst,
                        input logic freq, input logic [31:0] fadr, input logic fkill,
                        input logic dreq, input logic dwe, input logic [31:0] dadr,
                        input logic [31:0] dwdata, input logic [3:0] dmask,
                        input logic efg, input logic edg, input string tag);
        resp_t       e;
        resp_t       n;
        logic        x_en;
        logic        x_we;
        logic [31:0] x_adr;
        logic [31:0] x_wdata;
        logic [3:0]  x_wmask;
        reset      = rst_n;
        fetch_req  = freq;
        fetch_adr  = fadr;
        fetch_kill = fkill;
        data_req   = dreq;
        data_we    = dwe;
        data_adr   = dadr;
        data_wdata = dwdata;
        data_wmask = dmask;
        @(negedge clk);
        x_en = efg | edg;
        x_we = edg & dwe;
        x_adr = efg ? fadr : (edg ? dadr : 32'h0);
        x_wdata = edg ? dwdata : 32'h0;
        x_wmask = (edg && dwe) ? dmask : 4'h0;
        chk({tag, ".fetch_gnt"}, 32'(fetch_gnt), 32'(efg));
        chk({tag, ".data_gnt"}, 32'(data_gnt), 32'(edg));
        chk({tag, ".mem_en"}, 32'(mem_en), 32'(x_en));
        chk({tag, ".mem_we"}, 32'(mem_we), 32'(x_we));
        chk({tag, ".mem_adr"}, mem_adr, x_adr);
        chk({tag, ".mem_wmask"}, 32'(mem_wmask), 32'(x_wmask));
        if (!efg) chk({tag, ".mem_wdata"}, mem_wdata, x_wdata);
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, ".fetch_rvalid"}, 32'(fetch_rvalid), 32'(e.fv));
            chk({tag, ".fetch_rdata"}, fetch_rdata, e.fd);
            chk({tag, ".data_rvalid"}, 32'(data_rvalid), 32'(e.dv));
            chk({tag, ".data_rdata"}, data_rdata, e.dd);
        end
        n = '{fv: 1'b0, fd: 32'h0, dv: 1'b0, dd: 32'h0};
        if (rst_n && !pre_rst) begin
            if (efg && !fkill) begin
                n.fv = 1'b1;
                n.fd = ref_mem[fadr[7:2]];
            end
            if (edg && !dwe) begin
                n.dv = 1'b1;
                n.dd = ref_mem[dadr[7:2]];
            end
            if (edg && dwe) begin
                for (int b = 0; b < 4; b++) begin
                    if (dmask[b]) ref_mem[dadr[7:2]][8*b +: 8] = dwdata[8*b +: 8];
                end
            end
        end
        sb.push_back(n);
        if (pre_rst) begin
            #2;
            reset = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // Directed sequence.
    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]     = 32'hA000_0000 | (32'(i) * 32'h0001_0101);
            ref_mem[i] = 32'hA000_0000 | (32'(i) * 32'h0001_0101);
        end
        reset = 1'b0; fetch_req = 1'b0; fetch_adr = '0; fetch_kill = 1'b0;
        data_req = 1'b0; data_we = 1'b0; data_adr = '0; data_wdata = '0; data_wmask = '0;
        @(posedge clk);
        #1;
        sb.push_back('{fv: 1'b0, fd: 32'h0, dv: 1'b0, dd: 32'h0});

        // Reset held with both requesters active: no grants, no memory command.
        step(0, 0, 1, 32'h0, 0, 1, 0, 32'h10, 32'h0, 4'h0, 0, 0, "rst_hold");
        step(1, 0, 0, 32'h0, 0, 0, 0, 32'h0,  32'h0, 4'h0, 0, 0, "idle0");

        // Back-to-back fetches.
        step(1, 0, 1, 32'h0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, "fetch0");
        step(1, 0, 1, 32'h4, 0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, "fetch4");
        step(1, 0, 1, 32'h8, 0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, "fetch8");

        // Load collides with fetch: data first, fetch next cycle.
        step(1, 0, 1, 32'h0, 0, 1, 0, 32'h10, 32'h0, 4'h0, 0, 1, "coll_load");
        step(1, 0, 1, 32'h0, 0, 0, 0, 32'h0,  32'h0, 4'h0, 1, 0, "coll_fetch");

        // Continuous contention: fetch wins every fifth cycle.
        for (int c = 0; c < 10; c++) begin
            step(1, 0, 1, 32'h14 + 32'(4 * (c / 5)), 0, 1, 0, 32'h20 + 32'(4 * (c % 4)),
                 32'h0, 4'h0, (c % 5) == 4, (c % 5) != 4, "starve");
        end

        // An idle fetch cycle clears the partial starve count.
        step(1, 0, 1, 32'h1C, 0, 1, 0, 32'h30, 32'h0, 4'h0, 0, 1, "part0");
        step(1, 0, 1, 32'h1C, 0, 1, 0, 32'h34, 32'h0, 4'h0, 0, 1, "part1");
        step(1, 0, 0, 32'h1C, 0, 1, 0, 32'h38, 32'h0, 4'h0, 0, 1, "fetch_idle");
        for (int c = 0; c < 5; c++) begin
            step(1, 0, 1, 32'h1C, 0, 1, 0, 32'h3C, 32'h0, 4'h0, c == 4, c != 4, "restarve");
        end

        // Stores: no response; later loads see the written bytes.
        step(1, 0, 0, 32'h0, 0, 1, 1, 32'hC,  32'hDEADBEEF, 4'hF, 0, 1, "store_full");
        step(1, 0, 0, 32'h0, 0, 1, 1, 32'h24, 32'h12345678, 4'h3, 0, 1, "store_part");
        step(1, 0, 0, 32'h0, 0, 1, 0, 32'hC,  32'h0, 4'hF, 0, 1, "load_c");
        step(1, 0, 0, 32'h0, 0, 1, 0, 32'h24, 32'h0, 4'h0, 0, 1, "load_24");

        // Killed fetch returns nothing; kill without a fetch grant is ignored.
        step(1, 0, 1, 32'h8, 1, 0, 0, 32'h0,  32'h0, 4'h0, 1, 0, "fetch_kill");
        step(1, 0, 1, 32'hC, 0, 0, 0, 32'h0,  32'h0, 4'h0, 1, 0, "fetch_after_kill");
        step(1, 0, 0, 32'h0, 1, 1, 0, 32'h10, 32'h0, 4'h0, 0, 1, "kill_no_fetch");
        step(1, 0, 1, 32'h0, 1, 1, 0, 32'h14, 32'h0, 4'h0, 0, 1, "kill_denied");
        step(1, 0, 1, 32'h0, 0, 0, 0, 32'h0,  32'h0, 4'h0, 1, 0, "fetch_resume");

        // Reset at the edge after a load grant discards the response and the starve count.
        step(1, 0, 1, 32'h4, 0, 1, 0, 32'h18, 32'h0, 4'h0, 0, 1, "pre_rst0");
        step(1, 0, 1, 32'h4, 0, 1, 0, 32'h18, 32'h0, 4'h0, 0, 1, "pre_rst1");
        step(1, 1, 1, 32'h4, 0, 1, 0, 32'h10, 32'h0, 4'h0, 0, 1, "load_then_rst");
        step(0, 0, 1, 32'h4, 0, 1, 0, 32'h10, 32'h0, 4'h0, 0, 0, "in_rst0");
        step(0, 0, 1, 32'h4, 0, 1, 1, 32'h10, 32'h5, 4'hF, 0, 0, "in_rst1");
        step(1, 0, 0, 32'h0, 0, 0, 0, 32'h0,  32'h0, 4'h0, 0, 0, "post_rst_idle");
        for (int c = 0; c < 5; c++) begin
            step(1, 0, 1, 32'h4, 0, 1, 0, 32'h28, 32'h0, 4'h0, c == 4, c != 4, "post_rst_starve");
        end
        step(1, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, "drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
